// File: rtl/rs_error_correct_if.sv
// Stream bundle between the Chien/Forney stages and the RS correction stage.
// Latency: n/a (wiring only).
// Backpressure: none; producers must respect the overflow/underflow flags.
interface rs_error_correct_if #(
  parameter int M = 8
) ();
  logic         din_valid;
  logic [M-1:0] din;
  logic         err_valid;
  logic         err_loc;
  logic [M-1:0] err_val;
  logic         decode_fail;
  logic         dout_valid;
  logic [M-1:0] dout;
  logic         dout_sof;
  logic         dout_eof;
  logic         dout_msg;
  logic [3:0]   err_cnt;
  logic         frame_fail;
  logic         overflow;
  logic         underflow;

  modport master (
    output din_valid, din, err_valid, err_loc, err_val, decode_fail,
    input  dout_valid, dout, dout_sof, dout_eof, dout_msg,
           err_cnt, frame_fail, overflow, underflow
  );

  modport slave (
    input  din_valid, din, err_valid, err_loc, err_val, decode_fail,
    output dout_valid, dout, dout_sof, dout_eof, dout_msg,
           err_cnt, frame_fail, overflow, underflow
  );
endinterface

// File: rtl/rs_error_correct.sv
// RS(255,239) final stage: buffers received symbols, replays them XORing in Forney magnitudes at Chien roots.
// Latency: 2 cycles from an accepted err_valid strobe to dout_valid.
// Backpressure: none; writes to a full buffer are dropped (overflow), strobes on empty are ignored (underflow).
module rs_error_correct #(
  parameter int n  = 255,
  parameter int k  = 239,
  parameter int t  = 8,
  parameter int m  = 8,
  parameter int AW = 9
) (
  input  logic              clk_in,
  input  logic              rst_n,
  rs_error_correct_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam int IW    = $clog2(n);

  typedef enum logic {IDLE, CORRECT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   sym_idx_q, sym_idx_d, cur_idx;
  logic            last;

  logic [m-1:0]    mem [DEPTH];
  logic [m-1:0]    ram_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     occ;
  logic            full, empty, wr_en, rd_en;

  logic [3:0]      cnt_q, cnt_now;
  logic            fail_hold, fail_now, apply;

  logic            s1_vld, s1_loc, s1_sof, s1_eof, s1_msg, s1_fail;
  logic [m-1:0]    s1_val;
  logic [3:0]      s1_cnt;

  // Occupancy tops out at exactly DEPTH, so its MSB alone means full.
  assign full  = occ[AW];
  assign empty = (occ == '0);
  assign wr_en = bus.din_valid & ~full;
  assign rd_en = bus.err_valid & ~empty;

  // Circular buffer pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Frame buffer storage with registered read port (stage 1 data).
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= bus.din;
    if (rd_en) ram_q <= mem[rd_ptr];
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (bus.din_valid && full)  bus.overflow  <= 1'b1;
      if (bus.err_valid && empty) bus.underflow <= 1'b1;
    end
  end

  // Frame FSM state and symbol index register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sym_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      sym_idx_q <= sym_idx_d;
    end
  end

  // Next state, current symbol index and correction decision for this strobe.
  always_comb begin
    state_d   = state_q;
    sym_idx_d = sym_idx_q;
    cur_idx   = (state_q == IDLE) ? '0 : sym_idx_q;
    last      = (cur_idx == IW'(n - 1));
    fail_now  = fail_hold | bus.decode_fail;
    apply     = bus.err_loc & ~fail_now & (bus.err_val != '0);
    cnt_now   = (apply && cnt_q != 4'hF) ? cnt_q + 4'd1 : cnt_q;
    if (rd_en) begin
      if (last) begin
        state_d   = IDLE;
        sym_idx_d = '0;
      end else begin
        state_d   = CORRECT;
        sym_idx_d = cur_idx + 1'b1;
      end
    end
  end

  // Per-frame correction count and uncorrectable latch; both restart after the last symbol.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      fail_hold <= 1'b0;
    end else if (rd_en) begin
      cnt_q     <= last ? 4'd0 : cnt_now;
      fail_hold <= last ? 1'b0 : fail_now;
    end
  end

  // Stage 1: register strobe qualifiers alongside the RAM read.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_loc  <= 1'b0;
      s1_val  <= '0;
      s1_sof  <= 1'b0;
      s1_eof  <= 1'b0;
      s1_msg  <= 1'b0;
      s1_cnt  <= '0;
      s1_fail <= 1'b0;
    end else begin
      s1_vld <= rd_en;
      if (rd_en) begin
        s1_loc  <= bus.err_loc & ~fail_now;
        s1_val  <= bus.err_val;
        s1_sof  <= (state_q == IDLE);
        s1_eof  <= last;
        s1_msg  <= (cur_idx < IW'(k));
        s1_cnt  <= cnt_now;
        s1_fail <= fail_now | (cnt_now > 4'(t));
      end
    end
  end

  // Stage 2: apply the magnitude and publish frame statistics on the eof symbol.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout_valid <= 1'b0;
      bus.dout       <= '0;
      bus.dout_sof   <= 1'b0;
      bus.dout_eof   <= 1'b0;
      bus.dout_msg   <= 1'b0;
      bus.err_cnt    <= '0;
      bus.frame_fail <= 1'b0;
    end else begin
      bus.dout_valid <= s1_vld;
      bus.dout_sof   <= s1_vld & s1_sof;
      bus.dout_eof   <= s1_vld & s1_eof;
      bus.dout_msg   <= s1_vld & s1_msg;
      if (s1_vld) bus.dout <= ram_q ^ (s1_loc ? s1_val : '0);
      if (s1_vld && s1_eof) begin
        bus.err_cnt    <= s1_cnt;
        bus.frame_fail <= s1_fail;
      end
    end
  end
endmodule
